// File: rtl/enclave_pkg.sv
// enclave_pkg: opcodes, sequencer state encoding and lane-mask helper shared by the LWE datapath control.
`default_nettype none
package enclave_pkg;

  localparam logic [1:0] OP_ENCRYPT = 2'd0;
  localparam logic [1:0] OP_DECRYPT = 2'd1;
  localparam logic [1:0] OP_ADD     = 2'd2;
  localparam logic [1:0] OP_MULT    = 2'd3;

  localparam int MAX_LANES = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE_A = 3'd1,
    ST_ISSUE_B = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A remainder of zero means the final beat is full.
  function automatic logic [MAX_LANES-1:0] lane_mask_fn(input int unsigned rem,
                                                         input int unsigned lanes);
    logic [MAX_LANES-1:0] m;
    int                   n;
    n = (rem == 0) ? int'(lanes) : int'(rem);
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_beat_counter.sv
// ctrl_beat_counter: beat index, last-beat flag and per-beat lane mask for one operand stream.
`default_nettype none
module ctrl_beat_counter
  import enclave_pkg::*;
#(
  parameter int DIM_WIDTH = 4,
  parameter int LANES     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 restart,
  input  logic                 advance,
  input  logic                 clear,
  input  logic [DIM_WIDTH-1:0] dim,
  output logic                 last_beat,
  output logic [LANES-1:0]     lane_mask
);

  logic [DIM_WIDTH-1:0] beat;
  logic [DIM_WIDTH-1:0] last_idx;
  logic [DIM_WIDTH-1:0] new_last;
  logic [DIM_WIDTH-1:0] next_beat;
  logic [LANES-1:0]     tail_mask;
  logic [LANES-1:0]     new_tail;
  logic [DIM_WIDTH:0]   n_elems;

  always_comb begin
    n_elems   = {1'b0, dim} + 1'b1;
    new_last  = DIM_WIDTH'(32'(dim) / LANES);
    new_tail  = LANES'(lane_mask_fn(32'(n_elems) % LANES, LANES));
    next_beat = beat + 1'b1;
  end

  // restart replays the latched geometry for the second MULT stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat      <= '0;
      last_idx  <= '0;
      tail_mask <= '0;
      last_beat <= 1'b0;
      lane_mask <= '0;
    end else if (load) begin
      beat      <= '0;
      last_idx  <= new_last;
      tail_mask <= new_tail;
      last_beat <= (new_last == '0);
      lane_mask <= (new_last == '0) ? new_tail : '1;
    end else if (restart) begin
      beat      <= '0;
      last_beat <= (last_idx == '0);
      lane_mask <= (last_idx == '0) ? tail_mask : '1;
    end else if (advance) begin
      beat      <= next_beat;
      last_beat <= (next_beat == last_idx);
      lane_mask <= (next_beat == last_idx) ? tail_mask : '1;
    end else if (clear) begin
      last_beat <= 1'b0;
      lane_mask <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lwe_op_sequencer.sv
// lwe_op_sequencer: descriptor-driven operand/result address walker for the LWE datapath.
// Optional CTRL_PERF_CNT_EN adds perf_cycles/perf_stalls counters.
`default_nettype none
module lwe_op_sequencer
  import enclave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 4,
  parameter int MAX_DIM    = 10,
  parameter int LANES      = 1,
  parameter int PIPE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [1:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] op1_base,
  input  logic [ADDR_WIDTH-1:0] op2_base,
  input  logic [ADDR_WIDTH-1:0] out_base,
  input  logic [DIM_WIDTH-1:0]  dim,
  input  logic                  stall,
  output logic [1:0]            opcode_out,
  output logic [ADDR_WIDTH-1:0] op1_addr,
  output logic [ADDR_WIDTH-1:0] op2_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DIM_WIDTH-1:0]  row,
  output logic [LANES-1:0]      lane_mask,
  output logic                  op_select,
  output logic                  en,
  output logic                  busy,
  output logic                  done,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls,
`endif
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] ASTEP = ADDR_WIDTH'(LANES);
  localparam logic [DIM_WIDTH-1:0]  RSTEP = DIM_WIDTH'(LANES);
  localparam int                    DCW   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic           last_beat;
  logic           accept, dim_ok, consume, load, restart, advance, clear;

  assign cfg_ready = (state == ST_IDLE) || (state == ST_DONE);

  always_comb begin
    accept  = cfg_valid && cfg_ready;
    dim_ok  = (32'(dim) <= MAX_DIM);
    consume = en && !stall;
    load    = accept && dim_ok;
    restart = (state == ST_ISSUE_A) && consume && last_beat && (opcode_out == OP_MULT);
    advance = consume && !last_beat;
    clear   = consume && last_beat && !restart;
  end

  ctrl_beat_counter #(
    .DIM_WIDTH (DIM_WIDTH),
    .LANES     (LANES)
  ) u_beat_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .restart   (restart),
    .advance   (advance),
    .clear     (clear),
    .dim       (dim),
    .last_beat (last_beat),
    .lane_mask (lane_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      opcode_out <= '0;
      op1_addr   <= '0;
      op2_addr   <= '0;
      out_addr   <= '0;
      row        <= '0;
      op_select  <= 1'b0;
      en         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_ISSUE_A, ST_ISSUE_B: begin
          if (consume) begin
            if (restart) begin
              // op2_addr still holds op2_base: MULT phase A never advances it.
              state     <= ST_ISSUE_B;
              op_select <= 1'b1;
              row       <= '0;
              out_addr  <= out_addr + ASTEP;
            end else if (last_beat) begin
              en        <= 1'b0;
              drain_cnt <= '0;
              if (PIPE_DEPTH == 0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_DRAIN;
              end
            end else begin
              row <= row + RSTEP;
              if (state == ST_ISSUE_B) begin
                op2_addr <= op2_addr + ASTEP;
                out_addr <= out_addr + ASTEP;
              end else begin
                case (opcode_out)
                  OP_ENCRYPT, OP_DECRYPT: begin
                    op1_addr <= op1_addr + ASTEP;
                    op2_addr <= op2_addr + ASTEP;
                  end
                  OP_ADD: begin
                    op1_addr <= op1_addr + ASTEP;
                    op2_addr <= op2_addr + ASTEP;
                    out_addr <= out_addr + ASTEP;
                  end
                  default: begin
                    op1_addr <= op1_addr + ASTEP;
                    out_addr <= out_addr + ASTEP;
                  end
                endcase
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!stall) begin
            if (drain_cnt == DCW'(PIPE_DEPTH - 1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: ;
      endcase
      if (accept) begin
        if (!dim_ok) begin
          err <= 1'b1;
        end else begin
          state      <= ST_ISSUE_A;
          opcode_out <= opcode;
          op1_addr   <= op1_base;
          op2_addr   <= op2_base;
          out_addr   <= out_base;
          row        <= '0;
          op_select  <= 1'b0;
          en         <= 1'b1;
          busy       <= 1'b1;
        end
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (state != ST_IDLE) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (en && stall) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_lwe_op_sequencer.sv
// Directed bench for lwe_op_sequencer: descriptor table plus hand-written multi-cycle sequences.
`default_nettype none
`timescale 1ns/1ps
module tb_lwe_op_sequencer;
  import enclave_pkg::*;

  localparam int AW = 10;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_valid4 = 1'b0, stall = 1'b0;
  logic [1:0]    opcode = 2'd0;
  logic [AW-1:0] op1_base = '0, op2_base = '0, out_base = '0;
  logic [DW-1:0] dim = '0;

  logic          cfg_ready, op_select, en, busy, done, err;
  logic [1:0]    opcode_out;
  logic [AW-1:0] op1_addr, op2_addr, out_addr;
  logic [DW-1:0] row;
  logic [0:0]    lane_mask;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0]   perf_cycles, perf_stalls, perf_cycles4, perf_stalls4;
`endif

  logic          cfg_ready4, op_select4, en4, busy4, done4, err4;
  logic [1:0]    opcode_out4;
  logic [AW-1:0] op1_addr4, op2_addr4, out_addr4;
  logic [DW-1:0] row4;
  logic [3:0]    lane_mask4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lwe_op_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .MAX_DIM(10), .LANES(1), .PIPE_DEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .opcode(opcode),
    .op1_base(op1_base), .op2_base(op2_base), .out_base(out_base), .dim(dim), .stall(stall),
    .opcode_out(opcode_out), .op1_addr(op1_addr), .op2_addr(op2_addr), .out_addr(out_addr),
    .row(row), .lane_mask(lane_mask), .op_select(op_select), .en(en), .busy(busy), .done(done),
`ifdef CTRL_PERF_CNT_EN
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
`endif
    .err(err)
  );

  lwe_op_sequencer #(.ADDR_WIDTH(AW), .DIM_WIDTH(DW), .MAX_DIM(10), .LANES(4), .PIPE_DEPTH(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid4), .cfg_ready(cfg_ready4), .opcode(opcode),
    .op1_base(op1_base), .op2_base(op2_base), .out_base(out_base), .dim(dim), .stall(1'b0),
    .opcode_out(opcode_out4), .op1_addr(op1_addr4), .op2_addr(op2_addr4), .out_addr(out_addr4),
    .row(row4), .lane_mask(lane_mask4), .op_select(op_select4), .en(en4), .busy(busy4), .done(done4),
`ifdef CTRL_PERF_CNT_EN
    .perf_cycles(perf_cycles4), .perf_stalls(perf_stalls4),
`endif
    .err(err4)
  );

  typedef struct {
    logic [1:0]    opc;
    logic [AW-1:0] b1, b2, bo;
    logic [DW-1:0] dim;
    int            stall_at;
    int            stall_len;
    bit            exp_err;
    int            exp_beats;
    int            exp_done;
    logic [AW-1:0] e1, e2, eo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int            beats, stalled, cyc, nb, tot, j;
    bit            seen_done;
    logic [AW-1:0] e1, e2, eo, l1, l2, lo;
    logic [DW-1:0] er;
    logic          es;
    beats = 0; stalled = 0; seen_done = 0;
    l1 = '0; l2 = '0; lo = '0;
    nb  = int'(v.dim) + 1;
    tot = (v.opc == OP_MULT) ? 2 * nb : nb;
    opcode = v.opc; op1_base = v.b1; op2_base = v.b2; out_base = v.bo; dim = v.dim;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    if (v.exp_err) begin
      chk("err_pulse", {61'd0, err, en, cfg_ready}, 64'b101);
      step();
      chk("err_after", {60'd0, err, en, busy, cfg_ready}, 64'b0001);
      return;
    end
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin
        seen_done = 1;
        break;
      end
      if (beats < tot) begin
        stall = en && (beats == v.stall_at) && (stalled < v.stall_len);
        if (stall) stalled++;
        if (v.opc == OP_MULT && beats >= nb) begin
          j  = beats - nb;
          e1 = v.b1 + AW'(nb - 1);
          e2 = v.b2 + AW'(j);
          eo = v.bo + AW'(beats);
          er = DW'(j);
          es = 1'b1;
        end else begin
          e1 = v.b1 + AW'(beats);
          e2 = (v.opc == OP_MULT) ? v.b2 : v.b2 + AW'(beats);
          eo = (v.opc == OP_ADD || v.opc == OP_MULT) ? v.bo + AW'(beats) : v.bo;
          er = DW'(beats);
          es = 1'b0;
        end
        chk("beat", {24'd0, en, busy, op_select, opcode_out, row, op1_addr, op2_addr, out_addr, lane_mask},
            {24'd0, 1'b1, 1'b1, es, v.opc, er, e1, e2, eo, 1'b1});
        if (!stall) begin
          l1 = op1_addr; l2 = op2_addr; lo = out_addr;
          beats++;
        end
      end else begin
        stall = 1'b0;
        chk("drain", {62'd0, en, busy}, 64'b01);
      end
      step();
    end
    stall = 1'b0;
    chk("done_seen", 64'(seen_done), 64'd1);
    chk("done_cycle", 64'(cyc), 64'(v.exp_done));
    chk("beat_count", 64'(beats), 64'(v.exp_beats));
    chk("last_addrs", {34'd0, l1, l2, lo}, {34'd0, v.e1, v.e2, v.eo});
    chk("done_state", {60'd0, done, busy, en, cfg_ready}, 64'b1001);
    step();
    chk("post_done", {61'd0, done, busy, cfg_ready}, 64'b001);
`ifdef CTRL_PERF_CNT_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(v.exp_done));
    chk("perf_stalls", 64'(perf_stalls), 64'(v.stall_len));
`endif
  endtask

  initial begin : main
    int   cyc;
    int   cnt;
    bit   found;
    logic [3:0] m4 [3];
    m4[0] = 4'b1111; m4[1] = 4'b1111; m4[2] = 4'b0111;

    vecs[0] = '{OP_ENCRYPT, 10'h100, 10'h200, 10'h300, 4'd10, -1, 0, 1'b0, 11, 14, 10'h10A, 10'h20A, 10'h300};
    vecs[1] = '{OP_DECRYPT, 10'h010, 10'h020, 10'h030, 4'd0,  -1, 0, 1'b0, 1,  4,  10'h010, 10'h020, 10'h030};
    vecs[2] = '{OP_ADD,     10'h050, 10'h060, 10'h070, 4'd10,  5, 3, 1'b0, 11, 17, 10'h05A, 10'h06A, 10'h07A};
    vecs[3] = '{OP_MULT,    10'h000, 10'h040, 10'h080, 4'd3,  -1, 0, 1'b0, 8,  11, 10'h003, 10'h043, 10'h087};
    vecs[4] = '{OP_ENCRYPT, 10'h3FE, 10'h000, 10'h3FF, 4'd3,  -1, 0, 1'b0, 4,  7,  10'h001, 10'h003, 10'h3FF};
    vecs[5] = '{OP_ADD,     10'h001, 10'h002, 10'h003, 4'd11, -1, 0, 1'b1, 0,  0,  10'h000, 10'h000, 10'h000};
    vecs[6] = '{OP_MULT,    10'h3F0, 10'h100, 10'h3FA, 4'd10, -1, 0, 1'b0, 22, 25, 10'h3FA, 10'h10A, 10'h00F};
    vecs[7] = '{OP_MULT,    10'h200, 10'h210, 10'h220, 4'd1,   3, 2, 1'b0, 4,  9,  10'h201, 10'h211, 10'h223};

    step(); step();
    chk("reset_state", {25'd0, cfg_ready, opcode_out, op1_addr, op2_addr, out_addr, row, lane_mask, op_select, en, busy, done, err},
        {25'd0, 1'b1, 2'd0, 30'd0, 4'd0, 1'b0, 5'd0});
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Four-lane instance: 11 elements in beats of 4, tail beat carries 3 lanes.
    opcode = OP_ENCRYPT; op1_base = 10'h100; op2_base = 10'h200; out_base = 10'h300; dim = 4'd10;
    cfg_valid4 = 1'b1;
    step();
    cfg_valid4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("lanes4_beat", {21'd0, en4, busy4, err4, op_select4, opcode_out4, row4, op1_addr4, op2_addr4, out_addr4, lane_mask4},
          {21'd0, 1'b1, 1'b1, 1'b0, 1'b0, OP_ENCRYPT, 4'(4 * k), 10'h100 + 10'(4 * k), 10'h200 + 10'(4 * k), 10'h300, m4[k]});
      step();
    end
    chk("lanes4_drain", {61'd0, en4, busy4, cfg_ready4}, 64'b010);
    step();
    step();
    chk("lanes4_done", {62'd0, done4, cfg_ready4}, 64'b11);

    // Descriptor presented while busy stays pending and is taken in the DONE cycle.
    opcode = OP_ENCRYPT; op1_base = 10'h011; op2_base = 10'h022; out_base = 10'h033; dim = 4'd0;
    cfg_valid = 1'b1;
    step();
    opcode = OP_ADD; op1_base = 10'h044; op2_base = 10'h055; out_base = 10'h066; dim = 4'd1;
    chk("b2b_first", {52'd0, en, cfg_ready, op1_addr}, {52'd0, 1'b1, 1'b0, 10'h011});
    found = 0;
    for (cyc = 0; cyc < 10; cyc++) begin
      if (done) begin found = 1; break; end
      step();
    end
    chk("b2b_done1", 64'(found), 64'd1);
    step();
    cfg_valid = 1'b0;
    chk("b2b_second", {48'd0, en, busy, opcode_out, row, op1_addr, op2_addr}, {48'd0, 1'b1, 1'b1, OP_ADD, 4'd0, 10'h044, 10'h055});
    found = 0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      if (done) begin found = 1; break; end
      step();
    end
    chk("b2b_done2_cycle", 64'(found ? cyc : -1), 64'd5);
    step();

    // Reset during MULT second stream aborts without a done pulse.
    opcode = OP_MULT; op1_base = 10'h000; op2_base = 10'h040; out_base = 10'h080; dim = 4'd3;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    found = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      if (op_select) begin found = 1; break; end
      step();
    end
    chk("mult_phase_b_reached", 64'(found), 64'd1);
    step();
    rst_n = 1'b0;
    step();
    chk("abort_reset", {25'd0, cfg_ready, opcode_out, op1_addr, op2_addr, out_addr, row, lane_mask, op_select, en, busy, done, err},
        {25'd0, 1'b1, 2'd0, 30'd0, 4'd0, 1'b0, 5'd0});
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || en) cnt++;
      step();
    end
    chk("abort_no_done", 64'(cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
